// File: rtl/mul_dispatch.sv
// -----------------------------------------------------------------------------
// mul_dispatch
// Operand-side front end for the sequential shift-add multiplier. Operand
// pairs arrive on a valid/ready stream and are buffered in a small FIFO. They
// are issued one at a time on the multiplier's start/busy/done handshake, and
// each product is returned on a valid/ready output stream in push order.
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o     operand pair stream handshake
//   in_a_i, in_b_i              operand pair (WIDTH bits each)
//   mul_start_o                 one-cycle start pulse to the multiplier
//   mul_a_o, mul_b_o            operands held for the whole multiplication
//   mul_busy_i, mul_done_i      multiplier status; done is a one-cycle pulse
//   mul_result_i                product, valid in the mul_done_i cycle
//   out_valid_o / out_ready_i   product stream handshake
//   out_result_o                product (2*WIDTH bits)
//   level_o                     FIFO occupancy
// -----------------------------------------------------------------------------
module mul_dispatch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_a_i,
    input  logic [WIDTH-1:0]           in_b_i,
    output logic                       mul_start_o,
    output logic [WIDTH-1:0]           mul_a_o,
    output logic [WIDTH-1:0]           mul_b_o,
    input  logic                       mul_busy_i,
    input  logic                       mul_done_i,
    input  logic [2*WIDTH-1:0]         mul_result_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [2*WIDTH-1:0]         out_result_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e             state_r;
    logic [WIDTH-1:0]   mem_a_r [DEPTH];
    logic [WIDTH-1:0]   mem_b_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic               mul_start_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] out_result_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic out_take_s;
    logic slot_free_s;
    logic issue_s;

    // Full blocks pushes even when a pop happens on the same edge.
    assign full_s      = (level_r == LVL_W'(DEPTH));
    assign empty_s     = (level_r == LVL_W'(0));
    assign push_s      = in_valid_i && !full_s;
    assign out_take_s  = out_valid_r && out_ready_i;
    // The output register is free if empty or being drained this cycle, so a
    // capture can never overwrite an unconsumed product.
    assign slot_free_s = !out_valid_r || out_ready_i;
    assign issue_s     = (state_r == ST_IDLE) && !empty_s && !mul_busy_i && slot_free_s;

    assign in_ready_o   = !full_s;
    assign mul_start_o  = mul_start_r;
    assign mul_a_o      = mul_a_r;
    assign mul_b_o      = mul_b_r;
    assign out_valid_o  = out_valid_r;
    assign out_result_o = out_result_r;
    assign level_o      = level_r;

    // FIFO storage write; storage is RAM-like and needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_a_i;
            mem_b_r[wr_ptr_r] <= in_b_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, issue_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Issue FSM with registered multiplier and output-stream signals.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            mul_start_r  <= 1'b0;
            mul_a_r      <= '0;
            mul_b_r      <= '0;
            out_valid_r  <= 1'b0;
            out_result_r <= '0;
        end else begin
            // Consumption clears valid; a capture below on the same edge wins.
            if (out_take_s) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    // mul_done_i is deliberately ignored outside WAIT.
                    if (issue_s) begin
                        mul_a_r     <= mem_a_r[rd_ptr_r];
                        mul_b_r     <= mem_b_r[rd_ptr_r];
                        mul_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done_i) begin
                        out_result_r <= mul_result_i;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    mul_start_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
